mod_a_pipe: RTL and testbench
=============================

Name: mod_a_pipe

Overview:
Parametrised elastic register pipeline, next generation of the single-stage 8-bit register block. It moves DATA_W-bit words through STAGES registered stages with a valid/ready handshake on both sides, so downstream stalls are absorbed without data loss. It also provides a synchronous flush and an occupancy count. It sits between datapath modules as a retiming stage, and bubbles collapse while the pipe is stalled.

Parameters:
DATA_W, 8, data word width in bits (>=1)
STAGES, 2, number of register stages (>=1)
RESET_DATA, 0, reset value of every stage data register (DATA_W bits)

Ports:
clk  input  1  clock; all logic on rising edge
rst_x  input  1  asynchronous active-low reset
i_in_valid  input  1  upstream word valid
i_in  input  DATA_W  upstream word
o_in_ready  output  1  pipe accepts word this cycle
o_out_valid  output  1  output stage holds a word
o_out  output  DATA_W  output stage word
i_out_ready  input  1  downstream accepts word this cycle
i_flush  input  1  synchronous flush of all stages
o_count  output  $clog2(STAGES+1)  number of occupied stages

Behaviour:
- State: per stage k (0 = input side, STAGES-1 = output): valid bit v[k] and data register d[k].
- Reset (rst_x low, async):
  - all v[k] = 0 and all d[k] = RESET_DATA.
  - Resulting outputs: o_out_valid = 0, o_out = RESET_DATA, o_count = 0, o_in_ready = 1 (when i_flush is 0).
- Reset mid-operation discards all contents immediately. No handshake completes while rst_x is low.
- Move terms (combinational):
  - move[STAGES-1] = v[STAGES-1] & i_out_ready.
  - move[k] = v[k] & (~v[k+1] | move[k+1]).
- o_in_ready = ~i_flush & (~v[0] | move[0]).
- Transfer rules:
  - Input transfer: i_in_valid & o_in_ready.
  - Output transfer: o_out_valid & i_out_ready.
- Stage update at each edge (no flush):
  - stage k+1 loads d[k] when move[k].
  - stage 0 loads i_in on input transfer.
  - v[k] is set if loaded, cleared if it moved out and was not reloaded, and held otherwise.
- d[k] changes only when the stage loads. A stalled stage holds its data stable.
- o_out = d[STAGES-1], o_out_valid = v[STAGES-1]. Both are registered, with no combinational path from any input.
- Latency: a word accepted at edge N into an empty pipe is presented on o_out after edge N+STAGES-1, i.e. o_out_valid rises STAGES-1 cycles after acceptance. With STAGES=1 it appears the cycle after acceptance.
- Throughput: 1 word/cycle when i_out_ready is held high.
- Ordering: strictly FIFO, no duplication or loss.
- Full: when all v = 1 and i_out_ready = 0, o_in_ready = 0 and all contents hold.
- Full with i_out_ready = 1: all stages shift, o_in_ready = 1, and simultaneous in/out transfers keep o_count unchanged.
- Empty with i_out_ready = 0: the word fills down to the deepest empty stage, one stage per cycle.
- Flush (i_flush = 1):
  - o_in_ready = 0.
  - An output transfer in the flush cycle still completes; the consumer has taken the word.
  - At the next edge all v[k] = 0. Data registers are left unchanged.
- o_count = popcount(v), derived from registers only.
- Reset has priority over flush.

Optional Feature:
Macro: MOD_A_PIPE_PARITY_EN
- Defined:
  - Each stage stores an extra parity bit, set to the XOR of i_in at input transfer and carried alongside the data.
  - A new output o_perr (1 bit) is added. It is sticky: set at the edge after an output transfer whose o_out XOR differs from the carried parity bit.
  - o_perr is cleared only by reset or i_flush; reset value is 0.
  - Hidden test input i_perr_inject (1 bit) inverts the parity bit written at input transfer.
- Not defined: no parity storage, no o_perr and no i_perr_inject ports; behaviour is otherwise identical.

Test Plan:
- Reset: DATA_W=8, STAGES=2, RESET_DATA=8'h5A, rst_x low -> o_out=8'h5A, o_out_valid=0, o_count=0, o_in_ready=1.
- Streaming: i_out_ready=1, input 8'h01..8'h10 back-to-back -> o_out shows 8'h01..8'h10 in order, 1/cycle; first valid STAGES-1 cycles after first accept; o_in_ready stays 1.
- Backpressure:
  - i_out_ready=0, push 8'hA1, 8'hA2, 8'hA3 -> first two accepted, o_count=2, o_in_ready=0 on the third; o_out holds 8'hA1 stable.
  - Then raise i_out_ready -> 8'hA1, 8'hA2, 8'hA3 drained in order.
- Simultaneous in/out when full: o_count=2, i_in_valid=1, i_out_ready=1 for 4 cycles -> o_count remains 2, no word lost or duplicated.
- Flush: fill with 8'hC0, 8'hC1, assert i_flush with i_in_valid=1 (8'hFF) -> o_in_ready=0, 8'hFF dropped, next cycle o_count=0, o_out_valid=0.
- Reset mid-stream (and parity build): drop rst_x while o_count=2 -> outputs return to reset values asynchronously.
  - With MOD_A_PIPE_PARITY_EN, inject on 8'h33 -> o_perr=1 after that word's output transfer, and stays 1 until i_flush.

Source files
------------

// File: rtl/mod_a_pipe.sv
// Elastic valid/ready register pipeline of STAGES stages with flush and occupancy count.
// Optional per-stage parity tracking with sticky error flag: define MOD_A_PIPE_PARITY_EN.
module mod_a_pipe #(
  parameter int                DATA_W     = 8,
  parameter int                STAGES     = 2,
  parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
  input  logic                            clk,
  input  logic                            rst_x,
  input  logic                            i_in_valid,
  input  logic [DATA_W-1:0]               i_in,
  output logic                            o_in_ready,
  output logic                            o_out_valid,
  output logic [DATA_W-1:0]               o_out,
  input  logic                            i_out_ready,
  input  logic                            i_flush,
  output logic [$clog2(STAGES+1)-1:0]     o_count
`ifdef MOD_A_PIPE_PARITY_EN
  ,
  output logic                            o_perr,
  input  logic                            i_perr_inject
`endif
);

  localparam int CNT_W = $clog2(STAGES+1);

  logic [STAGES-1:0] v_reg;
  logic [STAGES-1:0] v_next;
  logic [STAGES-1:0] move;
  logic [STAGES-1:0] load;
  logic [DATA_W-1:0] d_reg [STAGES];
  logic [DATA_W-1:0] d_in  [STAGES];
  logic [CNT_W-1:0]  occ_count;
  logic              in_xfer;

  // A stage can shift forward if the next stage is empty or is itself shifting.
  always_comb begin
    move = '0;
    move[STAGES-1] = v_reg[STAGES-1] & i_out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      move[k] = v_reg[k] & (~v_reg[k+1] | move[k+1]);
    end
  end

  assign o_in_ready = ~i_flush & (~v_reg[0] | move[0]);
  assign in_xfer    = i_in_valid & o_in_ready;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign load[gi] = in_xfer;
        assign d_in[gi] = i_in;
      end else begin : g_body
        // Flush freezes data registers, so internal shifts are suppressed too.
        assign load[gi] = move[gi-1] & ~i_flush;
        assign d_in[gi] = d_reg[gi-1];
      end
      assign v_next[gi] = i_flush ? 1'b0 : (load[gi] | (v_reg[gi] & ~move[gi]));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      v_reg <= '0;
      for (int k = 0; k < STAGES; k++) begin
        d_reg[k] <= RESET_DATA;
      end
    end else begin
      v_reg <= v_next;
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          d_reg[k] <= d_in[k];
        end
      end
    end
  end

  always_comb begin
    occ_count = '0;
    for (int k = 0; k < STAGES; k++) begin
      occ_count = occ_count + CNT_W'(v_reg[k]);
    end
  end

  assign o_count     = occ_count;
  assign o_out       = d_reg[STAGES-1];
  assign o_out_valid = v_reg[STAGES-1];

`ifdef MOD_A_PIPE_PARITY_EN
  logic [STAGES-1:0] p_reg;
  logic [STAGES-1:0] p_in;
  logic              perr_reg;
  logic              out_xfer;

  assign out_xfer = v_reg[STAGES-1] & i_out_ready;

  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_par
      if (gi == 0) begin : g_head
        assign p_in[gi] = (^i_in) ^ i_perr_inject;
      end else begin : g_body
        assign p_in[gi] = p_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      p_reg    <= {STAGES{^RESET_DATA}};
      perr_reg <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          p_reg[k] <= p_in[k];
        end
      end
      if (i_flush) begin
        perr_reg <= 1'b0;
      end else if (out_xfer && ((^d_reg[STAGES-1]) != p_reg[STAGES-1])) begin
        perr_reg <= 1'b1;
      end
    end
  end

  assign o_perr = perr_reg;
`endif

endmodule

// File: tb/tb_mod_a_pipe.sv
// Self-checking bench for mod_a_pipe: queue-based reference model plus directed literal checks.
module tb_mod_a_pipe;

  localparam int          DATA_W = 8;
  localparam int          STAGES = 2;
  localparam logic [7:0]  RST_D  = 8'h5A;

  logic       clk;
  logic       rst_x;
  logic       i_in_valid;
  logic [7:0] i_in;
  logic       o_in_ready;
  logic       o_out_valid;
  logic [7:0] o_out;
  logic       i_out_ready;
  logic       i_flush;
  logic [1:0] o_count;
  logic       perr_inj;
`ifdef MOD_A_PIPE_PARITY_EN
  logic       o_perr;
`endif

  mod_a_pipe #(.DATA_W(DATA_W), .STAGES(STAGES), .RESET_DATA(RST_D)) dut (
    .clk         (clk),
    .rst_x       (rst_x),
    .i_in_valid  (i_in_valid),
    .i_in        (i_in),
    .o_in_ready  (o_in_ready),
    .o_out_valid (o_out_valid),
    .o_out       (o_out),
    .i_out_ready (i_out_ready),
    .i_flush     (i_flush),
    .o_count     (o_count)
`ifdef MOD_A_PIPE_PARITY_EN
    ,
    .o_perr        (o_perr),
    .i_perr_inject (perr_inj)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: words in FIFO order, each with its age in edges since acceptance.
  // The head word is visible at the output once it has had STAGES-1 edges to travel.
  typedef struct {
    logic [7:0] data;
    int         age;
    bit         bad;
  } ent_t;

  ent_t       mq[$];
  bit         m_perr;
  logic [7:0] rx[$];

  function automatic bit m_valid();
    return (mq.size() > 0) && (mq[0].age >= STAGES - 1);
  endfunction

  function automatic bit m_ready();
    return !i_flush && ((mq.size() < STAGES) || i_out_ready);
  endfunction

  always @(posedge clk or negedge rst_x) begin
    bit   ov;
    bit   ir;
    bit   pset;
    ent_t e;
    if (!rst_x) begin
      mq.delete();
      m_perr = 1'b0;
    end else begin
      ov   = m_valid();
      ir   = m_ready();
      pset = 1'b0;
      if (ov && i_out_ready) begin
        pset = mq[0].bad;
        void'(mq.pop_front());
      end
      foreach (mq[i]) mq[i].age++;
      if (i_in_valid && ir) begin
        e.data = i_in;
        e.age  = 0;
        e.bad  = perr_inj;
        mq.push_back(e);
      end
      if (i_flush) begin
        mq.delete();
        m_perr = 1'b0;
      end else if (pset) begin
        m_perr = 1'b1;
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_x) begin
      chk("m_out_valid", 32'(o_out_valid), 32'(m_valid()));
      chk("m_in_ready", 32'(o_in_ready), 32'(m_ready()));
      chk("m_count", 32'(o_count), 32'(mq.size()));
      if (m_valid()) chk("m_out_data", 32'(o_out), 32'(mq[0].data));
`ifdef MOD_A_PIPE_PARITY_EN
      chk("m_perr", 32'(o_perr), 32'(m_perr));
`endif
      if (o_out_valid && i_out_ready) rx.push_back(o_out);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rx(input string nm, input logic [7:0] first, input int n);
    logic [7:0] w;
    chk({nm, "_len"}, 32'(rx.size()), 32'(n));
    for (int i = 0; i < n && i < rx.size(); i++) begin
      w = first + 8'(i);
      chk({nm, "_word"}, 32'(rx[i]), 32'(w));
    end
  endtask

  initial begin
    rst_x       = 1'b0;
    i_in_valid  = 1'b0;
    i_in        = '0;
    i_out_ready = 1'b0;
    i_flush     = 1'b0;
    perr_inj    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", 32'(o_out), 32'h5A);
    chk("rst_valid", 32'(o_out_valid), 32'd0);
    chk("rst_count", 32'(o_count), 32'd0);
    chk("rst_ready", 32'(o_in_ready), 32'd1);
    #2 rst_x = 1'b1;
    step();

    // Streaming 01..10 with downstream always ready
    rx.delete();
    i_out_ready = 1'b1;
    i_in_valid  = 1'b1;
    i_in        = 8'h01;
    step();
    chk("stream_lat_edge0", 32'(o_out_valid), 32'd0);
    i_in = 8'h02;
    step();
    chk("stream_lat_edge1", 32'(o_out_valid), 32'd1);
    chk("stream_first", 32'(o_out), 32'h01);
    for (int i = 3; i <= 16; i++) begin
      i_in = 8'(i);
      chk("stream_ready", 32'(o_in_ready), 32'd1);
      step();
    end
    i_in_valid = 1'b0;
    repeat (4) step();
    chk_rx("stream", 8'h01, 16);

    // Backpressure
    rx.delete();
    i_out_ready = 1'b0;
    i_in_valid  = 1'b1;
    i_in        = 8'hA1;
    step();
    i_in = 8'hA2;
    step();
    i_in = 8'hA3;
    chk("bp_count", 32'(o_count), 32'd2);
    chk("bp_ready", 32'(o_in_ready), 32'd0);
    chk("bp_hold0", 32'(o_out), 32'hA1);
    step();
    step();
    chk("bp_hold2", 32'(o_out), 32'hA1);
    chk("bp_count2", 32'(o_count), 32'd2);
    i_out_ready = 1'b1;
    step();
    i_in_valid = 1'b0;
    repeat (4) step();
    chk_rx("bp_drain", 8'hA1, 3);

    // Simultaneous in/out while full
    rx.delete();
    i_out_ready = 1'b0;
    i_in_valid  = 1'b1;
    i_in        = 8'hB0;
    step();
    i_in = 8'hB1;
    step();
    i_out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      i_in = 8'hB2 + 8'(j);
      step();
      chk("full_count", 32'(o_count), 32'd2);
    end
    i_in_valid = 1'b0;
    repeat (4) step();
    chk_rx("full_seq", 8'hB0, 6);

`ifdef MOD_A_PIPE_PARITY_EN
    // Parity error injection on 8'h33
    i_out_ready = 1'b1;
    i_in_valid  = 1'b1;
    perr_inj    = 1'b1;
    i_in        = 8'h33;
    step();
    perr_inj = 1'b0;
    i_in     = 8'h34;
    chk("perr_before", 32'(o_perr), 32'd0);
    step();
    i_in_valid = 1'b0;
    step();
    step();
    chk("perr_set", 32'(o_perr), 32'd1);
    repeat (3) step();
    chk("perr_sticky", 32'(o_perr), 32'd1);
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    chk("perr_clear", 32'(o_perr), 32'd0);
    step();
`endif

    // Flush
    i_out_ready = 1'b0;
    i_in_valid  = 1'b1;
    i_in        = 8'hC0;
    step();
    i_in = 8'hC1;
    step();
    i_flush = 1'b1;
    i_in    = 8'hFF;
    chk("flush_ready", 32'(o_in_ready), 32'd0);
    step();
    i_flush    = 1'b0;
    i_in_valid = 1'b0;
    chk("flush_count", 32'(o_count), 32'd0);
    chk("flush_valid", 32'(o_out_valid), 32'd0);
    chk("flush_data_kept", 32'(o_out), 32'hC0);
    step();
    chk("flush_dropped", 32'(o_count), 32'd0);

    // Reset mid-stream
    i_in_valid = 1'b1;
    i_in       = 8'hD0;
    step();
    i_in = 8'hD1;
    step();
    i_in_valid = 1'b0;
    chk("mid_count_pre", 32'(o_count), 32'd2);
    #3 rst_x = 1'b0;
    #1;
    chk("mid_rst_out", 32'(o_out), 32'h5A);
    chk("mid_rst_valid", 32'(o_out_valid), 32'd0);
    chk("mid_rst_count", 32'(o_count), 32'd0);
    chk("mid_rst_ready", 32'(o_in_ready), 32'd1);
    @(negedge clk);
    #2 rst_x = 1'b1;
    step();
    chk("post_rst_count", 32'(o_count), 32'd0);
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
